reservation_station: RTL and testbench

Consumer end of the dispatch interface: accepts one `disp_packet_t` per cycle from rename/dispatch and holds it until both source operands are ready. It snoops the writeback tag broadcast for wakeup and issues up to one ready instruction per functional unit per cycle to the execution pipes. It sits between dispatch and the NUM_FUS execution pipes.

---
 rtl/reservation_station_pkg.sv | 50 +++++
 rtl/reservation_station_if.sv | 33 +++
 rtl/reservation_station_select.sv | 15 +
 rtl/reservation_station.sv | 133 +++++++++++++
 tb/tb_reservation_station.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station slice.
// Holds the sizing constants, the execution-pipe enum (enum value = pipe
// index), the dispatch packet, the RS entry record and the writeback tag
// matcher used both at dispatch and for wakeup of resident entries.
package reservation_station_pkg;

  localparam int RS_ENTRIES = 32;
  localparam int NUM_FUS    = 4;
  localparam int NUM_PREGS  = 64;
  localparam int PREG_W     = $clog2(NUM_PREGS);
  localparam int OCC_W      = $clog2(RS_ENTRIES) + 1;

  typedef enum logic [$clog2(NUM_FUS)-1:0] {
    EX_ALU0 = 2'd0,
    EX_ALU1 = 2'd1,
    EX_MUL  = 2'd2,
    EX_MEM  = 2'd3
  } ex_pipe_e;

  typedef struct packed {
    logic              instr_valid;
    logic [7:0]        opcode;
    logic [PREG_W-1:0] dst_preg;
    logic [PREG_W-1:0] src1_preg;
    logic              src1_dp_en;
    logic [PREG_W-1:0] src2_preg;
    logic              src2_dp_en;
    ex_pipe_e          ex_pipe_dst;
  } disp_packet_t;

  typedef struct packed {
    logic         valid;
    logic         rdy1;
    logic         rdy2;
    disp_packet_t pkt;
  } rs_entry_t;

  localparam int PKT_W = $bits(disp_packet_t);

  // Any valid broadcast port carrying this tag. Plain equality; preg 0 is
  // an ordinary tag.
  function automatic logic tag_hit(input logic [NUM_FUS-1:0]             v,
                                   input logic [NUM_FUS-1:0][PREG_W-1:0] tags,
                                   input logic [PREG_W-1:0]              p);
    tag_hit = 1'b0;
    for (int k = 0; k < NUM_FUS; k++)
      if (v[k] && (tags[k] == p)) tag_hit = 1'b1;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch / wakeup / issue bundle of the reservation station.
// slave : RS side (consumes dispatch + writeback tags, produces issue).
// master: environment side (rename/dispatch, writeback, execution pipes).
// Signals: disp_pkt_i, src1_rdy_i, src2_rdy_i, disp_ready_o, wb_valid_i,
//          wb_preg_i, fu_ready_i, iss_valid_o, iss_pkt_o, flush_i,
//          occupancy_o.
interface reservation_station_if;
  import reservation_station_pkg::*;

  disp_packet_t                         disp_pkt_i;
  logic                                 src1_rdy_i;
  logic                                 src2_rdy_i;
  logic                                 disp_ready_o;
  logic [NUM_FUS-1:0]                   wb_valid_i;
  logic [NUM_FUS-1:0][PREG_W-1:0]       wb_preg_i;
  logic [NUM_FUS-1:0]                   fu_ready_i;
  logic [NUM_FUS-1:0]                   iss_valid_o;
  disp_packet_t [NUM_FUS-1:0]           iss_pkt_o;
  logic                                 flush_i;
  logic [OCC_W-1:0]                     occupancy_o;

  modport slave (
    input  disp_pkt_i, src1_rdy_i, src2_rdy_i, wb_valid_i, wb_preg_i,
           fu_ready_i, flush_i,
    output disp_ready_o, iss_valid_o, iss_pkt_o, occupancy_o
  );

  modport master (
    output disp_pkt_i, src1_rdy_i, src2_rdy_i, wb_valid_i, wb_preg_i,
           fu_ready_i, flush_i,
    input  disp_ready_o, iss_valid_o, iss_pkt_o, occupancy_o
  );
endinterface

// File: rtl/reservation_station_select.sv
// rs_select: lowest-index fixed-priority picker.
// req : request vector (N bits)
// gnt : one-hot grant of the lowest set request bit (zero if none)
// vld : at least one request present
module rs_select #(
  parameter int N = 32
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         vld
);
  // Two's-complement isolate-lowest-set-bit.
  assign gnt = req & (~req + N'(1));
  assign vld = |req;
endmodule

// File: rtl/reservation_station.sv
// reservation_station: holds dispatched packets until both sources are
// ready, snoops writeback tags for wakeup, issues at most one packet per
// execution pipe per cycle (lowest index first).
// Ports: clk, rst (synchronous, active high), bus (reservation_station_if
//        slave modport: dispatch, wakeup, issue, flush, occupancy).
// Build option: RS_WAKEUP_BYPASS_EN lets the current-cycle broadcast count
//        toward eligibility (back-to-back dependent issue, adds a wb->iss
//        combinational path). Undefined: eligibility from registered ready
//        bits only.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  reservation_station_if.slave  bus
);

  rs_entry_t                            ent [RS_ENTRIES];
  logic [OCC_W-1:0]                     occ;
  logic                                 disp_rdy, accept, free_vld;
  logic [RS_ENTRIES-1:0]                free_req, free_gnt;
  logic [RS_ENTRIES-1:0]                wk1, wk2, fire_mask;
  logic [NUM_FUS-1:0][RS_ENTRIES-1:0]   elig, gnt;
  logic [NUM_FUS-1:0]                   gvld, iss_vld, fire;
  disp_packet_t [NUM_FUS-1:0]           iss_pkt;
  logic [OCC_W-1:0]                     n_fire;
  logic                                 disp_r1, disp_r2;

  // Registered-state based; a same-cycle issue does not free a slot early.
  assign disp_rdy = (occ < OCC_W'(RS_ENTRIES));
  assign accept   = bus.disp_pkt_i.instr_valid & disp_rdy & free_vld & ~bus.flush_i;

  // A source with no dependency is ready; otherwise busy table or a tag
  // broadcast landing in the dispatch cycle (so that wakeup is not missed).
  assign disp_r1 = ~bus.disp_pkt_i.src1_dp_en | bus.src1_rdy_i |
                   tag_hit(bus.wb_valid_i, bus.wb_preg_i, bus.disp_pkt_i.src1_preg);
  assign disp_r2 = ~bus.disp_pkt_i.src2_dp_en | bus.src2_rdy_i |
                   tag_hit(bus.wb_valid_i, bus.wb_preg_i, bus.disp_pkt_i.src2_preg);

  always_comb begin
    free_req = '0;
    wk1      = '0;
    wk2      = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      free_req[i] = ~ent[i].valid;
      wk1[i] = ent[i].pkt.src1_dp_en &
               tag_hit(bus.wb_valid_i, bus.wb_preg_i, ent[i].pkt.src1_preg);
      wk2[i] = ent[i].pkt.src2_dp_en &
               tag_hit(bus.wb_valid_i, bus.wb_preg_i, ent[i].pkt.src2_preg);
    end
  end

  always_comb begin
    logic r1, r2;
    elig = '0;
    r1   = 1'b0;
    r2   = 1'b0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
      r1 = ent[i].rdy1 | wk1[i];
      r2 = ent[i].rdy2 | wk2[i];
`else
      r1 = ent[i].rdy1;
      r2 = ent[i].rdy2;
`endif
      for (int k = 0; k < NUM_FUS; k++)
        elig[k][i] = ent[i].valid & r1 & r2 & (int'(ent[i].pkt.ex_pipe_dst) == k);
    end
  end

  rs_select #(.N(RS_ENTRIES)) u_free (
    .req (free_req),
    .gnt (free_gnt),
    .vld (free_vld)
  );

  rs_select #(.N(RS_ENTRIES)) u_sel [NUM_FUS-1:0] (
    .req (elig),
    .gnt (gnt),
    .vld (gvld)
  );

  // Issue valid never depends on fu_ready; flush masks it outright.
  assign iss_vld = gvld & {NUM_FUS{~bus.flush_i}};
  assign fire    = iss_vld & bus.fu_ready_i;

  always_comb begin
    logic [PKT_W-1:0] acc;
    acc     = '0;
    iss_pkt = '0;
    for (int k = 0; k < NUM_FUS; k++) begin
      acc = '0;
      for (int i = 0; i < RS_ENTRIES; i++)
        acc = acc | ({PKT_W{gnt[k][i]}} & ent[i].pkt);
      iss_pkt[k] = iss_vld[k] ? disp_packet_t'(acc) : '0;
    end
  end

  always_comb begin
    fire_mask = '0;
    n_fire    = '0;
    for (int k = 0; k < NUM_FUS; k++) begin
      fire_mask = fire_mask | (gnt[k] & {RS_ENTRIES{fire[k]}});
      n_fire    = n_fire + OCC_W'(fire[k]);
    end
  end

  // Only valid bits and the count are cleared; payload of a free entry is
  // never observed because issue is qualified by valid.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      for (int i = 0; i < RS_ENTRIES; i++) ent[i].valid <= 1'b0;
      occ <= '0;
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (ent[i].valid) begin
          if (wk1[i])       ent[i].rdy1  <= 1'b1;
          if (wk2[i])       ent[i].rdy2  <= 1'b1;
          if (fire_mask[i]) ent[i].valid <= 1'b0;
        end else if (accept && free_gnt[i]) begin
          ent[i] <= '{valid: 1'b1, rdy1: disp_r1, rdy2: disp_r2, pkt: bus.disp_pkt_i};
        end
      end
      occ <= occ + OCC_W'(accept) - n_fire;
    end
  end

  assign bus.disp_ready_o = disp_rdy;
  assign bus.occupancy_o  = occ;
  assign bus.iss_valid_o  = iss_vld;
  assign bus.iss_pkt_o    = iss_pkt;

endmodule

// File: tb/tb_reservation_station.sv
// Testbench for reservation_station: table of single-packet dispatch
// vectors plus hand-written multi-cycle sequences (wakeup latency, full
// back-pressure, four-pipe issue, flush). Expected issued packets are
// queued when dispatched and popped by a monitor when the DUT fires.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reservation_station_if bus();

  reservation_station dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           pipe;
    disp_packet_t pkt;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int                 pipe;
    int                 s1;
    logic               e1;
    logic               r1;
    int                 s2;
    logic               e2;
    logic               r2;
    logic [NUM_FUS-1:0] wbv;
    int                 wt[NUM_FUS];
    logic               exp_iss;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue monitor: every fire must match the oldest outstanding expectation
  // for that pipe; idle pipes must present an all-zero packet.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int k = 0; k < NUM_FUS; k++) begin
        if (bus.iss_valid_o[k] && bus.fu_ready_i[k]) begin
          int idx;
          idx = -1;
          for (int j = 0; j < sb.size(); j++)
            if (idx < 0 && sb[j].pipe == k) idx = j;
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue pipe %0d: got pkt %0h expected no issue", k, bus.iss_pkt_o[k]);
          end else begin
            chk($sformatf("issue_pkt_p%0d", k), 64'(bus.iss_pkt_o[k]), 64'(sb[idx].pkt));
            sb.delete(idx);
          end
        end else if (!bus.iss_valid_o[k]) begin
          chk($sformatf("idle_pkt_zero_p%0d", k), 64'(bus.iss_pkt_o[k]), 64'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    bus.disp_pkt_i = '0;
    bus.src1_rdy_i = 1'b0;
    bus.src2_rdy_i = 1'b0;
    bus.wb_valid_i = '0;
    bus.wb_preg_i  = '0;
    bus.flush_i    = 1'b0;
  endtask

  function automatic disp_packet_t mk(input int pipe, input int dst, input int s1,
                                      input logic e1, input int s2, input logic e2);
    disp_packet_t p;
    p             = '0;
    p.instr_valid = 1'b1;
    p.opcode      = 8'(dst + 128);
    p.dst_preg    = PREG_W'(dst);
    p.src1_preg   = PREG_W'(s1);
    p.src1_dp_en  = e1;
    p.src2_preg   = PREG_W'(s2);
    p.src2_dp_en  = e2;
    p.ex_pipe_dst = ex_pipe_e'(pipe);
    return p;
  endfunction

  function automatic vec_t mkv(input int pipe, input int s1, input logic e1, input logic r1,
                               input int s2, input logic e2, input logic r2,
                               input logic [NUM_FUS-1:0] wbv,
                               input int t0, input int t1, input int t2, input int t3,
                               input logic exp_iss);
    vec_t v;
    v.pipe = pipe; v.s1 = s1; v.e1 = e1; v.r1 = r1;
    v.s2 = s2; v.e2 = e2; v.r2 = r2; v.wbv = wbv;
    v.wt[0] = t0; v.wt[1] = t1; v.wt[2] = t2; v.wt[3] = t3;
    v.exp_iss = exp_iss;
    return v;
  endfunction

  task automatic disp(input disp_packet_t p, input logic r1, input logic r2);
    bus.disp_pkt_i = p;
    bus.src1_rdy_i = r1;
    bus.src2_rdy_i = r2;
  endtask

  task automatic push(input disp_packet_t p);
    sb_t e;
    e.pipe = int'(p.ex_pipe_dst);
    e.pkt  = p;
    sb.push_back(e);
  endtask

  vec_t         vt[8];
  disp_packet_t p, pa, pb, p0, p1;
  logic [3:0]   exp_v;

  initial begin
    vt[0] = mkv(2,  1,1'b0,1'b0,  2,1'b0,1'b0, 4'b0000,  0, 0, 0, 0, 1'b1);
    vt[1] = mkv(0,  9,1'b1,1'b0,  2,1'b0,1'b0, 4'b0000,  0, 0, 0, 0, 1'b0);
    vt[2] = mkv(1,  3,1'b0,1'b0, 12,1'b1,1'b0, 4'b1000,  0, 0, 0,12, 1'b1);
    vt[3] = mkv(3,  0,1'b1,1'b0,  2,1'b0,1'b0, 4'b0001,  0, 0, 0, 0, 1'b1);
    vt[4] = mkv(0,  7,1'b1,1'b1,  8,1'b1,1'b0, 4'b0001,  9, 0, 0, 0, 1'b0);
    vt[5] = mkv(1,  3,1'b1,1'b0,  4,1'b1,1'b0, 4'b0101,  3, 0, 4, 0, 1'b1);
    vt[6] = mkv(2, 10,1'b1,1'b0,  2,1'b0,1'b0, 4'b0000, 10,10,10,10, 1'b0);
    vt[7] = mkv(3, 40,1'b1,1'b1, 41,1'b1,1'b1, 4'b0000,  0, 0, 0, 0, 1'b1);

    // Reset
    rst = 1'b1;
    idle();
    bus.fu_ready_i = '0;
    tick();
    tick();
    settle();
    chk("rst_occupancy", 64'(bus.occupancy_o), 64'd0);
    chk("rst_disp_ready", 64'(bus.disp_ready_o), 64'd1);
    chk("rst_iss_valid", 64'(bus.iss_valid_o), 64'd0);
    chk("rst_iss_pkt", 64'(|bus.iss_pkt_o), 64'd0);
    rst = 1'b0;
    tick();

    // Single-packet vectors: dispatch, check issue the next cycle, flush.
    bus.fu_ready_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      p = mk(vt[i].pipe, 5 + i, vt[i].s1, vt[i].e1, vt[i].s2, vt[i].e2);
      disp(p, vt[i].r1, vt[i].r2);
      bus.wb_valid_i = vt[i].wbv;
      for (int k = 0; k < NUM_FUS; k++) bus.wb_preg_i[k] = PREG_W'(vt[i].wt[k]);
      if (vt[i].exp_iss) push(p);
      settle();
      chk($sformatf("vec%0d_disp_ready", i), 64'(bus.disp_ready_o), 64'd1);
      chk($sformatf("vec%0d_iss_dispatch_cycle", i), 64'(bus.iss_valid_o), 64'd0);
      tick();
      idle();
      settle();
      exp_v = vt[i].exp_iss ? 4'(1 << vt[i].pipe) : 4'b0000;
      chk($sformatf("vec%0d_iss_valid", i), 64'(bus.iss_valid_o), 64'(exp_v));
      chk($sformatf("vec%0d_occ_after_disp", i), 64'(bus.occupancy_o), 64'd1);
      tick();
      settle();
      chk($sformatf("vec%0d_occ_after_fire", i), 64'(bus.occupancy_o), vt[i].exp_iss ? 64'd0 : 64'd1);
      bus.flush_i = 1'b1;
      tick();
      idle();
    end

    // Wakeup latency: src1 waits on preg 9, broadcast arrives later.
    p = mk(0, 20, 9, 1'b1, 2, 1'b0);
    disp(p, 1'b0, 1'b0);
    push(p);
    tick();
    idle();
    settle();
    chk("wk_wait0", 64'(bus.iss_valid_o), 64'd0);
    tick();
    settle();
    chk("wk_wait1", 64'(bus.iss_valid_o), 64'd0);
    tick();
    bus.wb_valid_i   = 4'b0010;
    bus.wb_preg_i[1] = PREG_W'(9);
    settle();
`ifdef RS_WAKEUP_BYPASS_EN
    chk("wk_iss_bcast_cycle", 64'(bus.iss_valid_o), 64'd1);
    tick();
    idle();
    settle();
    chk("wk_occ_after", 64'(bus.occupancy_o), 64'd0);
`else
    chk("wk_iss_bcast_cycle", 64'(bus.iss_valid_o), 64'd0);
    tick();
    idle();
    settle();
    chk("wk_iss_next_cycle", 64'(bus.iss_valid_o), 64'd1);
    tick();
    settle();
    chk("wk_occ_after", 64'(bus.occupancy_o), 64'd0);
`endif
    tick();

    // Dispatch and issue in the same cycle keep occupancy unchanged.
    pa = mk(2, 30, 1, 1'b0, 2, 1'b0);
    disp(pa, 1'b0, 1'b0);
    push(pa);
    tick();
    pb = mk(1, 31, 13, 1'b1, 2, 1'b0);
    disp(pb, 1'b0, 1'b0);
    settle();
    chk("di_iss_valid", 64'(bus.iss_valid_o), 64'd4);
    chk("di_occ_before", 64'(bus.occupancy_o), 64'd1);
    tick();
    idle();
    settle();
    chk("di_occ_unchanged", 64'(bus.occupancy_o), 64'd1);
    chk("di_blocked_no_iss", 64'(bus.iss_valid_o), 64'd0);
    bus.flush_i = 1'b1;
    tick();
    idle();

    // Fill all entries on pipe 0 with the pipe stalled.
    bus.fu_ready_i = 4'b0000;
    p0 = mk(0, 0, 2, 1'b0, 2, 1'b0);
    p1 = mk(0, 1, 2, 1'b0, 2, 1'b0);
    for (int i = 0; i < RS_ENTRIES; i++) begin
      p = mk(0, i, 2, 1'b0, 2, 1'b0);
      disp(p, 1'b1, 1'b1);
      push(p);
      tick();
    end
    idle();
    settle();
    chk("full_occ", 64'(bus.occupancy_o), 64'd32);
    chk("full_disp_ready", 64'(bus.disp_ready_o), 64'd0);
    chk("full_iss_valid", 64'(bus.iss_valid_o), 64'd1);
    chk("full_winner", 64'(bus.iss_pkt_o[0]), 64'(p0));
    tick();
    disp(mk(1, 63, 2, 1'b0, 2, 1'b0), 1'b1, 1'b1);
    settle();
    chk("full_hold_winner", 64'(bus.iss_pkt_o[0]), 64'(p0));
    tick();
    idle();
    bus.fu_ready_i = 4'b0001;
    settle();
    chk("full_drop_occ", 64'(bus.occupancy_o), 64'd32);
    chk("full_fire_cycle_ready", 64'(bus.disp_ready_o), 64'd0);
    tick();
    bus.fu_ready_i = 4'b0000;
    settle();
    chk("full_after_fire_ready", 64'(bus.disp_ready_o), 64'd1);
    chk("full_after_fire_occ", 64'(bus.occupancy_o), 64'd31);
    chk("full_next_winner", 64'(bus.iss_pkt_o[0]), 64'(p1));
    bus.flush_i = 1'b1;
    sb.delete();
    tick();
    idle();

    // One ready entry per pipe, all fire together.
    for (int k = 0; k < NUM_FUS; k++) begin
      p = mk(k, 40 + k, 2, 1'b0, 2, 1'b0);
      disp(p, 1'b0, 1'b0);
      push(p);
      tick();
    end
    idle();
    settle();
    chk("four_occ", 64'(bus.occupancy_o), 64'd4);
    chk("four_iss_valid", 64'(bus.iss_valid_o), 64'hf);
    bus.fu_ready_i = 4'b1111;
    tick();
    bus.fu_ready_i = 4'b0000;
    settle();
    chk("four_occ_after", 64'(bus.occupancy_o), 64'd0);
    chk("four_iss_after", 64'(bus.iss_valid_o), 64'd0);
    tick();

    // Flush with 10 entries, an incoming dispatch and a wakeup broadcast.
    for (int i = 0; i < 5; i++) begin
      disp(mk(3, 50 + i, 2, 1'b0, 2, 1'b0), 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      disp(mk(1, 55 + i, 20, 1'b1, 2, 1'b0), 1'b0, 1'b0);
      tick();
    end
    idle();
    settle();
    chk("fl_occ_before", 64'(bus.occupancy_o), 64'd10);
    chk("fl_iss_before", 64'(bus.iss_valid_o), 64'd8);
    tick();
    bus.flush_i      = 1'b1;
    bus.fu_ready_i   = 4'b1111;
    disp(mk(2, 60, 2, 1'b0, 2, 1'b0), 1'b0, 1'b0);
    bus.wb_valid_i   = 4'b0001;
    bus.wb_preg_i[0] = PREG_W'(20);
    settle();
    chk("fl_iss_forced_low", 64'(bus.iss_valid_o), 64'd0);
    tick();
    idle();
    settle();
    chk("fl_occ_after", 64'(bus.occupancy_o), 64'd0);
    chk("fl_disp_ready_after", 64'(bus.disp_ready_o), 64'd1);
    chk("fl_no_iss_after", 64'(bus.iss_valid_o), 64'd0);
    tick();
    bus.wb_valid_i   = 4'b0001;
    bus.wb_preg_i[0] = PREG_W'(20);
    settle();
    chk("fl_no_iss_rewake", 64'(bus.iss_valid_o), 64'd0);
    tick();
    idle();
    settle();
    chk("fl_no_iss_late", 64'(bus.iss_valid_o), 64'd0);
    tick();
    tick();
    settle();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
